count_delta_packer: RTL

Downstream consumer of the 8-bit counter stage's count output. Samples count every cycle and detects each change. Records the modular delta and a wrap flag into a small FIFO, drained through a valid/ready interface. The data array is written only on push (enable-style registers, no reset), so synthesis can clock-gate it, in line with the low-power flow this stage belongs to.

---
 rtl/count_delta_packer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/count_delta_packer.sv
// Change-delta recorder for the upstream counter stage; each change of
// count pushes {delta, wrap} into a small FIFO drained by valid/ready.
// Ports: clk, rst (sync, active-high), count, ovf_clr, out_ready,
//   out_valid, out_delta, out_wrap, fifo_level, overflow.
// Option macro DELTA_STATS_EN adds stat_sum and stat_max outputs.
module count_delta_packer #(
  parameter int CW    = 8,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] count,
  input  logic          ovf_clr,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [CW-1:0] out_delta,
  output logic          out_wrap,
  output logic [LW-1:0] fifo_level,
`ifdef DELTA_STATS_EN
  output logic          overflow,
  output logic [15:0]   stat_sum,
  output logic [CW-1:0] stat_max
`else
  output logic          overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] prev_q, prev_d;
  logic [LW-1:0] level_q;
  logic [AW-1:0] rd_q, wr_q;
  logic          ovf_q;

  logic [CW-1:0] mem_delta [DEPTH];
  logic          mem_wrap  [DEPTH];

  logic          change;
  logic          pop;
  logic          accept;
  logic          drop;
  logic [CW-1:0] delta;
  logic          wrap;

  // Next-state and push decode
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    change  = 1'b0;
    unique case (state_q)
      PRIME: begin
        prev_d  = count;
        state_d = RUN;
      end
      RUN: begin
        change = (count != prev_q);
        if (change) prev_d = count;
      end
      default: state_d = PRIME;
    endcase
  end

  assign delta  = count - prev_q;
  assign wrap   = (count < prev_q);
  assign pop    = out_valid && out_ready;
  // A pop in the same cycle frees the slot being written.
  assign accept = change && ((level_q < FULL) || pop);
  assign drop   = change && !accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRIME;
      prev_q  <= '0;
      level_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      if (accept) wr_q <= wr_q + 1'b1;
      if (pop)    rd_q <= rd_q + 1'b1;
      unique case ({accept, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // Storage has no reset so it can be clock-gated on push.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem_delta[wr_q] <= delta;
      mem_wrap[wr_q]  <= wrap;
    end
  end

  assign out_valid  = (level_q != '0);
  assign out_delta  = out_valid ? mem_delta[rd_q] : '0;
  assign out_wrap   = out_valid ? mem_wrap[rd_q] : 1'b0;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

`ifdef DELTA_STATS_EN
  logic [15:0]   sum_q;
  logic [CW-1:0] max_q;
  logic [16:0]   sum_ext;

  assign sum_ext = {1'b0, sum_q} + 17'(out_delta);

  always_ff @(posedge clk) begin
    if (rst || ovf_clr) begin
      sum_q <= '0;
      max_q <= '0;
    end else if (pop) begin
      sum_q <= sum_ext[16] ? 16'hFFFF : sum_ext[15:0];
      if (out_delta > max_q) max_q <= out_delta;
    end
  end

  assign stat_sum = sum_q;
  assign stat_max = max_q;
`endif

endmodule
